signed_sum_accumulator: RTL
===========================

SIGNED_SUM_ACCUMULATOR -- requirements
Module: signed_sum_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 9: operand width index; input sample is DATA_WIDTH+2 bits, matching the upstream signed adder sum width.
REQ-002 SHALL have parameter ACC_WIDTH, default 12: accumulator and result width in bits; ACC_WIDTH >= DATA_WIDTH+2.
REQ-003 SHALL have parameter LEN_WIDTH, default 8: width of the burst-length field.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  starts a burst; sampled only in IDLE.
REQ-007 len  input  LEN_WIDTH  number of samples in the burst, unsigned; sampled with start.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 in_data  input  DATA_WIDTH+2, signed  sample from the upstream signed adder.
REQ-011 out_valid  output  1  result is valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_data  output  ACC_WIDTH, signed  saturated burst sum.
REQ-014 out_sat  output  1  sticky flag: saturation occurred at least once in this burst.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-017 In IDLE, start=1 with len>0 SHALL clear acc and out_sat, load cnt=len, and enter ACCUM.
REQ-018 In IDLE, start=1 with len=0 SHALL enter HOLD with out_data=0 and out_sat=0.
REQ-019 start SHALL be ignored in ACCUM and HOLD.
REQ-020 in_ready SHALL be 1 only in ACCUM, and SHALL be a registered-state decode with no combinational path from in_valid.
REQ-021 A beat SHALL transfer when in_valid=1 and in_ready=1.
REQ-022 On each beat: acc <= sat(acc + sign-extended in_data) and cnt <= cnt-1.
REQ-023 Without a beat, acc and cnt SHALL hold their values; idle gaps on in_valid SHALL be tolerated indefinitely.
REQ-024 Saturation:
- a sum above 2^(ACC_WIDTH-1)-1 SHALL clamp to that maximum;
- a sum below -2^(ACC_WIDTH-1) SHALL clamp to that minimum;
- any clamp SHALL set out_sat, which stays set until the next accepted start.
REQ-025 Accumulation SHALL continue from the clamped value (saturating, not wrapping).
REQ-026 The beat taken with cnt=1 SHALL move the FSM to HOLD; out_valid SHALL rise on the next cycle, one cycle after the last beat.
REQ-027 In HOLD:
- out_valid=1;
- out_data and out_sat SHALL remain stable until out_ready=1;
- out_valid=1 and out_ready=1 SHALL return the FSM to IDLE on the next cycle.
REQ-028 After returning to IDLE, out_data and out_sat SHALL hold their last values, and out_valid=0.
REQ-029 Throughput SHALL be one sample per cycle in ACCUM; start SHALL be accepted in the first IDLE cycle after the handshake.

Reset
REQ-030 rst_n=0 SHALL immediately, regardless of clk, force:
- state=IDLE;
- acc=0, cnt=0;
- out_data=0, out_sat=0;
- out_valid=0, in_ready=0, busy=0.
REQ-031 Reset asserted mid-burst SHALL discard the partial sum; no out_valid SHALL follow deassertion without a new start.
REQ-032 Reset deassertion SHALL be followed by IDLE behaviour from the first clock edge.

Structure
REQ-033 Package signed_acc_pkg SHALL hold:
- the state enum typedef (IDLE, ACCUM, HOLD);
- the default DATA_WIDTH, ACC_WIDTH and LEN_WIDTH localparams.
REQ-034 Saturating add SHALL be a combinational sub-module signed_sat_add, parameterised by input and accumulator widths, with outputs sum and sat.
REQ-035 The FSM, counter and registers SHALL reside in signed_sum_accumulator.

Verification (defaults DATA_WIDTH=9, ACC_WIDTH=12; input range -1024..1023, result range -2048..2047)
REQ-036 start, len=4, in_data 1, 3, -1, 3 back-to-back -> out_valid one cycle after the 4th beat, out_data=6, out_sat=0.
REQ-037 len=3, in_data 1023, 1023, 1023 -> out_data=2047, out_sat=1; len=2, in_data -1024, -1024 -> out_data=-2048, out_sat=0.
REQ-038 len=2, in_data -511, -9 with in_valid gapped 3 cycles between beats -> out_data=-520; in_ready high throughout ACCUM.
REQ-039 out_ready held 0 for 5 cycles in HOLD -> out_valid and out_data stable; start pulsed during HOLD ignored; a start after the handshake is accepted.
REQ-040 start, len=0 -> out_valid next cycle with out_data=0.
REQ-041 rst_n pulsed low after 2 of 4 beats -> outputs zero immediately, no out_valid afterwards until a new start.

Source files
------------

// File: rtl/signed_acc_pkg.sv
// Shared types and default widths for the signed burst accumulator.
package signed_acc_pkg;

  localparam int DEF_DATA_WIDTH = 9;
  localparam int DEF_ACC_WIDTH  = 12;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/signed_sat_add.sv
// Combinational saturating adder: signed accumulator plus sign-extended signed sample.
module signed_sat_add #(
  parameter int IN_WIDTH  = 11,
  parameter int ACC_WIDTH = 12
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  input  logic signed [IN_WIDTH-1:0]  add_i,
  output logic signed [ACC_WIDTH-1:0] sum,
  output logic                        sat
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH:0] wideSum;

  // One guard bit is enough: overflow shows up as the two top bits disagreeing.
  always_comb begin
    wideSum = {acc_i[ACC_WIDTH-1], acc_i}
            + {{(ACC_WIDTH+1-IN_WIDTH){add_i[IN_WIDTH-1]}}, add_i};
    sat     = 1'b0;
    sum     = wideSum[ACC_WIDTH-1:0];
    if (wideSum[ACC_WIDTH] != wideSum[ACC_WIDTH-1]) begin
      sat = 1'b1;
      sum = wideSum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

endmodule

// File: rtl/signed_sum_accumulator.sv
// Sums a burst of len signed samples with saturation and holds the result until taken.
module signed_sum_accumulator
  import signed_acc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [LEN_WIDTH-1:0]        len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_WIDTH+1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        out_sat,
  output logic                        busy
);

  state_e                      state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        sat_q, sat_d;

  logic signed [ACC_WIDTH-1:0] addSum;
  logic                        addSat;

  signed_sat_add #(
    .IN_WIDTH  (DATA_WIDTH + 2),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat_add (
    .acc_i (acc_q),
    .add_i (in_data),
    .sum   (addSum),
    .sat   (addSat)
  );

  // Handshake outputs decode only the registered state, so in_ready never depends on in_valid.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign out_sat   = sat_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          sat_d = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = ACCUM;
          end else begin
            cnt_d   = '0;
            state_d = HOLD;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = addSum;
          sat_d = sat_q | addSat;
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

endmodule
